// File: rtl/difftest_commit_buf.sv
// Multi-lane retirement buffer: compacts up to IN_W retired instructions per cycle into a FIFO,
// drains them one per cycle to the difftest commit port, and tracks trap and performance state.
module difftest_commit_buf #(
   parameter int unsigned IN_W  = 2,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IN_W-1:0]   in_valid,
   input  logic [IN_W*64-1:0] in_pc,
   input  logic [IN_W*32-1:0] in_inst,
   input  logic [IN_W-1:0]   in_wen,
   input  logic [IN_W*5-1:0] in_wdest,
   input  logic [IN_W*64-1:0] in_wdata,
   input  logic [63:0]       a0_data,
   output logic              in_ready,
   output logic              cmt_valid,
   output logic [63:0]       cmt_pc,
   output logic [31:0]       cmt_inst,
   output logic              cmt_wen,
   output logic [7:0]        cmt_wdest,
   output logic [63:0]       cmt_wdata,
   input  logic              cmt_ready,
   output logic              trap,
   output logic [7:0]        trap_code,
   output logic [63:0]       trap_pc,
   output logic [63:0]       cycle_cnt,
   output logic [63:0]       instr_cnt,
   output logic [CNT_W-1:0]  count
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] ReadyMax = CNT_W'(DEPTH - IN_W);

   typedef logic [PtrW-1:0] ptr_t;

   logic [63:0] pc_mem    [DEPTH];
   logic [31:0] inst_mem  [DEPTH];
   logic        wen_mem   [DEPTH];
   logic [4:0]  wdest_mem [DEPTH];
   logic [63:0] wdata_mem [DEPTH];
   logic        tag_mem   [DEPTH];

   ptr_t             head_q, tail_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             trap_q, trap_pending_q;
   logic [7:0]       trap_code_q;
   logic [63:0]      trap_pc_q;
   logic [63:0]      cycle_q, instr_q;

   logic [IN_W-1:0]  keep, lane_trap;
   logic             trap_hit;
   logic [63:0]      hit_pc;
   logic [CNT_W-1:0] push_n;
   ptr_t             slot [IN_W];
   logic             accept, pop;
   logic             unused_a0;

   assign unused_a0 = ^a0_data[63:8];

   // Lanes after the first valid trap are dropped; each kept lane lands at tail + #kept-below-it.
   always_comb begin
      keep      = '0;
      lane_trap = '0;
      trap_hit  = 1'b0;
      hit_pc    = '0;
      push_n    = '0;
      for (int k = 0; k < IN_W; k++) begin
         slot[k] = tail_q + PtrW'(push_n);
         if (in_valid[k] && !trap_hit) begin
            keep[k] = 1'b1;
            push_n  = push_n + CNT_W'(1);
            if (in_inst[32*k +: 7] == 7'h6b) begin
               lane_trap[k] = 1'b1;
               trap_hit     = 1'b1;
               hit_pc       = in_pc[64*k +: 64];
            end
         end
      end
   end

   assign in_ready  = (count_q <= ReadyMax) & ~trap_pending_q;
   assign accept    = in_ready & (|in_valid);
   assign cmt_valid = (count_q != '0);
   assign pop       = cmt_valid & cmt_ready;
   assign count_d   = count_q + (accept ? push_n : '0) - CNT_W'(pop);

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < IN_W; k++) begin
            if (keep[k]) begin
               pc_mem[slot[k]]    <= in_pc[64*k +: 64];
               inst_mem[slot[k]]  <= in_inst[32*k +: 32];
               wen_mem[slot[k]]   <= in_wen[k];
               wdest_mem[slot[k]] <= in_wdest[5*k +: 5];
               wdata_mem[slot[k]] <= in_wdata[64*k +: 64];
               tag_mem[slot[k]]   <= lane_trap[k];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         trap_q         <= 1'b0;
         trap_pending_q <= 1'b0;
         trap_code_q    <= '0;
         trap_pc_q      <= '0;
         cycle_q        <= '0;
         instr_q        <= '0;
      end else begin
         count_q <= count_d;
         if (accept) begin
            tail_q <= tail_q + PtrW'(push_n);
            if (trap_hit) begin
               trap_pending_q <= 1'b1;
               trap_code_q    <= a0_data[7:0];
               trap_pc_q      <= hit_pc;
            end
         end
         if (pop) begin
            head_q  <= head_q + ptr_t'(1);
            instr_q <= instr_q + 64'd1;
            if (tag_mem[head_q]) begin
               trap_q <= 1'b1;
            end
         end
         if (!trap_q) begin
            cycle_q <= cycle_q + 64'd1;
         end
      end
   end

   // Fields read as zero while empty so nothing stale leaks out after reset.
   assign cmt_pc    = cmt_valid ? pc_mem[head_q] : '0;
   assign cmt_inst  = cmt_valid ? inst_mem[head_q] : '0;
   assign cmt_wen   = cmt_valid ? wen_mem[head_q] : 1'b0;
   assign cmt_wdest = cmt_valid ? {3'b000, wdest_mem[head_q]} : '0;
   assign cmt_wdata = cmt_valid ? wdata_mem[head_q] : '0;

   assign trap      = trap_q;
   assign trap_code = trap_code_q;
   assign trap_pc   = trap_pc_q;
   assign cycle_cnt = cycle_q;
   assign instr_cnt = instr_q;
   assign count     = count_q;

endmodule

// File: tb/tb_difftest_commit_buf.sv
// Scoreboard bench for difftest_commit_buf: directed groups push expected entries, a negedge
// monitor compares every commit handshake in order.
module tb_difftest_commit_buf;

   localparam int unsigned IN_W  = 2;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        wen;
      logic [4:0]  wdest;
      logic [63:0] wdata;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [IN_W-1:0]   in_valid;
   logic [IN_W*64-1:0] in_pc;
   logic [IN_W*32-1:0] in_inst;
   logic [IN_W-1:0]   in_wen;
   logic [IN_W*5-1:0] in_wdest;
   logic [IN_W*64-1:0] in_wdata;
   logic [63:0]       a0_data;
   logic              in_ready;
   logic              cmt_valid;
   logic [63:0]       cmt_pc;
   logic [31:0]       cmt_inst;
   logic              cmt_wen;
   logic [7:0]        cmt_wdest;
   logic [63:0]       cmt_wdata;
   logic              cmt_ready;
   logic              trap;
   logic [7:0]        trap_code;
   logic [63:0]       trap_pc;
   logic [63:0]       cycle_cnt;
   logic [63:0]       instr_cnt;
   logic [CNT_W-1:0]  count;

   int   checks = 0;
   int   errors = 0;
   ent_t sb[$];
   longint unsigned edges;
   longint unsigned frz;
   ent_t z;

   difftest_commit_buf #(.IN_W(IN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .in_wen    (in_wen),
      .in_wdest  (in_wdest),
      .in_wdata  (in_wdata),
      .a0_data   (a0_data),
      .in_ready  (in_ready),
      .cmt_valid (cmt_valid),
      .cmt_pc    (cmt_pc),
      .cmt_inst  (cmt_inst),
      .cmt_wen   (cmt_wen),
      .cmt_wdest (cmt_wdest),
      .cmt_wdata (cmt_wdata),
      .cmt_ready (cmt_ready),
      .trap      (trap),
      .trap_code (trap_code),
      .trap_pc   (trap_pc),
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt),
      .count     (count)
   );

   always #5 clk = ~clk;

   // Reference cycle counter: posedges seen since the last reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   always @(negedge clk) begin
      ent_t e;
      if (rst_n && cmt_valid && cmt_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL commit_unexpected got pc=%h inst=%h with empty scoreboard", cmt_pc,
                     cmt_inst);
         end else begin
            e = sb.pop_front();
            if ({cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata} !==
                {e.pc, e.inst, e.wen, {3'b000, e.wdest}, e.wdata}) begin
               errors++;
               $display("FAIL commit_entry got pc=%h inst=%h wen=%b wdest=%h wdata=%h exp pc=%h inst=%h wen=%b wdest=%h wdata=%h",
                        cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata,
                        e.pc, e.inst, e.wen, e.wdest, e.wdata);
            end
         end
      end
   end

   function automatic ent_t mk(input logic [63:0] pc, input logic [31:0] inst, input logic wen,
                               input logic [4:0] wdest, input logic [63:0] wdata);
      ent_t e;
      e.pc = pc; e.inst = inst; e.wen = wen; e.wdest = wdest; e.wdata = wdata;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, act, exp);
      end
   endtask

   // Waits (bounded) for in_ready, drives one group for one edge and records the entries the
   // buffer must deliver: valid lanes in order, stopping after the first trap lane.
   task automatic send(input logic [1:0] v, input ent_t l0, input ent_t l1, input logic [63:0] a0);
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL send_wait_ready got %b exp 1", in_ready);
         return;
      end
      in_valid = v;
      in_pc    = {l1.pc, l0.pc};
      in_inst  = {l1.inst, l0.inst};
      in_wen   = {l1.wen, l0.wen};
      in_wdest = {l1.wdest, l0.wdest};
      in_wdata = {l1.wdata, l0.wdata};
      a0_data  = a0;
      if (v[0]) sb.push_back(l0);
      if (v[1] && !(v[0] && l0.inst[6:0] == 7'h6b)) sb.push_back(l1);
      tick();
      in_valid = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      z = mk(64'h0, 32'h0, 1'b0, 5'd0, 64'h0);
      rst_n = 1'b0; cmt_ready = 1'b0; in_valid = '0; in_pc = '0; in_inst = '0;
      in_wen = '0; in_wdest = '0; in_wdata = '0; a0_data = '0;
      #12;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_cmt_valid", 64'(cmt_valid), 64'd0);
      chk("rst_trap", 64'(trap), 64'd0);
      chk("rst_instr_cnt", instr_cnt, 64'd0);
      chk("rst_cycle_cnt", cycle_cnt, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single push
      cmt_ready = 1'b1;
      send(2'b01, mk(64'h8000_0000, 32'h0000_0013, 1'b1, 5'd5, 64'h1234), z, 64'h0);
      chk("single_valid", 64'(cmt_valid), 64'd1);
      chk("single_wdest", 64'(cmt_wdest), 64'd5);
      chk("single_pc", cmt_pc, 64'h8000_0000);
      tick();
      chk("single_instr_cnt", instr_cnt, 64'd1);
      chk("single_count", 64'(count), 64'd0);

      // Compaction: only lane 1 valid
      cmt_ready = 1'b0;
      send(2'b10, z, mk(64'h8000_0004, 32'h0000_0093, 1'b1, 5'd6, 64'h55), 64'h0);
      chk("compact_count", 64'(count), 64'd1);
      chk("compact_pc", cmt_pc, 64'h8000_0004);
      cmt_ready = 1'b1;
      tick();
      cmt_ready = 1'b0;
      chk("compact_drained", 64'(count), 64'd0);

      // Fill and free
      for (int g = 0; g < 4; g++) begin
         send(2'b11,
              mk(64'h8000_0100 + 64'(16 * g), 32'h0010_0013 + 32'(g), 1'b1, 5'(2 * g), 64'(100 + g)),
              mk(64'h8000_0108 + 64'(16 * g), 32'h0020_0013 + 32'(g), 1'b0, 5'(2 * g + 1),
                 64'(200 + g)),
              64'h0);
      end
      chk("fill_count", 64'(count), 64'd8);
      chk("fill_in_ready", 64'(in_ready), 64'd0);
      cmt_ready = 1'b1; tick(); cmt_ready = 1'b0;
      chk("pop1_count", 64'(count), 64'd7);
      chk("pop1_in_ready", 64'(in_ready), 64'd0);
      cmt_ready = 1'b1; tick(); cmt_ready = 1'b0;
      chk("pop2_count", 64'(count), 64'd6);
      chk("pop2_in_ready", 64'(in_ready), 64'd1);
      cmt_ready = 1'b1;
      repeat (6) tick();
      chk("fill_drained", 64'(count), 64'd0);
      chk("fill_instr_cnt", instr_cnt, 64'd10);

      // Async reset with five entries queued
      cmt_ready = 1'b0;
      send(2'b11, mk(64'hA0, 32'h13, 1'b1, 5'd1, 64'h1), mk(64'hA4, 32'h13, 1'b1, 5'd2, 64'h2), 64'h0);
      send(2'b11, mk(64'hA8, 32'h13, 1'b1, 5'd3, 64'h3), mk(64'hAC, 32'h13, 1'b1, 5'd4, 64'h4), 64'h0);
      send(2'b01, mk(64'hB0, 32'h13, 1'b1, 5'd5, 64'h5), z, 64'h0);
      chk("pre_reset_count", 64'(count), 64'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_cmt_valid", 64'(cmt_valid), 64'd0);
      chk("async_count", 64'(count), 64'd0);
      chk("async_trap", 64'(trap), 64'd0);
      chk("async_cycle_cnt", cycle_cnt, 64'd0);
      chk("async_instr_cnt", instr_cnt, 64'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_reset_in_ready", 64'(in_ready), 64'd1);

      // Wrap-around: 20 single-lane pushes streamed straight through
      cmt_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         send(2'b01, mk(64'h8000_2000 + 64'(4 * i), 32'h13 | (32'(i) << 7), 1'b1, 5'(i),
                        64'hC000 + 64'(i)), z, 64'h0);
      end
      tick();
      chk("wrap_instr_cnt", instr_cnt, 64'd20);
      chk("wrap_count", 64'(count), 64'd0);
      chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

      // Trap truncation
      cmt_ready = 1'b0;
      send(2'b11, mk(64'h8000_3000, 32'h0000_006b, 1'b0, 5'd0, 64'h0),
           mk(64'h8000_3004, 32'h0000_0013, 1'b1, 5'd1, 64'h1), 64'h2A);
      chk("trap_push_count", 64'(count), 64'd1);
      chk("trap_in_ready", 64'(in_ready), 64'd0);
      chk("trap_before_pop", 64'(trap), 64'd0);
      cmt_ready = 1'b1;
      tick();
      chk("trap_set", 64'(trap), 64'd1);
      chk("trap_code", 64'(trap_code), 64'h2A);
      chk("trap_pc", trap_pc, 64'h8000_3000);
      chk("trap_instr_cnt", instr_cnt, 64'd21);
      frz = edges;
      chk("trap_cycle_cnt", cycle_cnt, frz);
      repeat (3) tick();
      chk("trap_cycle_frozen", cycle_cnt, frz);
      chk("trap_in_ready_held", 64'(in_ready), 64'd0);
      chk("trap_count_empty", 64'(count), 64'd0);
      chk("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
